// File: rtl/arcade_sync_mixer.sv
// Arcade video front-end: sync polarity normalisation, pixel capture on ce_pix rising edge,
// packed-RGB expansion to 8 bits per channel and a registered VGA-style output stage.

module arcade_sync_pol #(
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic fixed
);
    localparam logic [CNT_W-1:0] ONE = 1;

    logic             s1, s2, pol;
    logic [CNT_W-1:0] cnt, pos, neg;

    // Measure high and low times; the longer phase is taken as the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            pos <= '0;
            neg <= '0;
            pol <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s1 != s2)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + ONE;
            if (s1 && !s2)
                neg <= cnt;
            if (!s1 && s2)
                pos <= cnt;
            pol <= (pos > neg);
        end
    end

    assign fixed = raw ^ pol;
endmodule

module arcade_sync_mixer #(
    parameter int DW         = 8,
    parameter bit HALF_DEPTH = 1'b1,
    parameter int CNT_W      = 20
) (
    input  logic          clk_video,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [DW-1:0] RGB_in,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic          HSync,
    input  logic          VSync,
    input  logic [2:0]    fx,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic [1:0]    VGA_SL,
    output logic          CE_PIXEL
);
    logic          hs_fixed, vs_fixed;
    logic          old_ce, ce, ce_edge;
    logic          hs, vs, hbl, vbl, de;
    logic [DW-1:0] rgb_fix;
    logic [7:0]    r8, g8, b8, r_x, g_x, b_x;
    logic [2:0]    fx_m1;
    logic [1:0]    sl;

    arcade_sync_pol #(.CNT_W(CNT_W)) u_hs_pol (
        .clk(clk_video), .rst(reset), .raw(HSync), .fixed(hs_fixed)
    );
    arcade_sync_pol #(.CNT_W(CNT_W)) u_vs_pol (
        .clk(clk_video), .rst(reset), .raw(VSync), .fixed(vs_fixed)
    );

    assign ce_edge = ce_pix & ~old_ce;

    // VS only moves at an hsync leading edge and VBL only at the end of hblank,
    // so vertical state changes are aligned to line boundaries.
    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            old_ce  <= 1'b0;
            ce      <= 1'b0;
            rgb_fix <= '0;
            hs      <= 1'b0;
            vs      <= 1'b0;
            hbl     <= 1'b0;
            vbl     <= 1'b0;
        end else begin
            old_ce <= ce_pix;
            ce     <= ce_edge;
            if (ce_edge) begin
                rgb_fix <= RGB_in;
                hs      <= hs_fixed;
                hbl     <= HBlank;
                if (!hs && hs_fixed)
                    vs <= vs_fixed;
                if (hbl && !HBlank)
                    vbl <= VBlank;
            end
        end
    end

    generate
        if (DW == 6) begin : g_dw6
            assign r8 = {4{rgb_fix[5:4]}};
            assign g8 = {4{rgb_fix[3:2]}};
            assign b8 = {4{rgb_fix[1:0]}};
        end else if (DW == 8) begin : g_dw8
            assign r8 = {rgb_fix[7:5], rgb_fix[7:5], rgb_fix[7:6]};
            assign g8 = {rgb_fix[4:2], rgb_fix[4:2], rgb_fix[4:3]};
            assign b8 = {4{rgb_fix[1:0]}};
        end else if (DW == 9) begin : g_dw9
            assign r8 = {rgb_fix[8:6], rgb_fix[8:6], rgb_fix[8:7]};
            assign g8 = {rgb_fix[5:3], rgb_fix[5:3], rgb_fix[5:4]};
            assign b8 = {rgb_fix[2:0], rgb_fix[2:0], rgb_fix[2:1]};
        end else if (DW == 12) begin : g_dw12
            assign r8 = {rgb_fix[11:8], rgb_fix[11:8]};
            assign g8 = {rgb_fix[7:4], rgb_fix[7:4]};
            assign b8 = {rgb_fix[3:0], rgb_fix[3:0]};
        end else begin : g_dw24
            localparam int LIM = (DW < 24) ? DW : 24;
            logic [23:0] rgb24;
            always_comb begin
                rgb24 = '0;
                for (int i = 0; i < LIM; i++)
                    rgb24[i] = rgb_fix[i];
            end
            assign r8 = rgb24[23:16];
            assign g8 = rgb24[15:8];
            assign b8 = rgb24[7:0];
        end
    endgenerate

    assign r_x   = HALF_DEPTH ? {r8[7:4], r8[7:4]} : r8;
    assign g_x   = HALF_DEPTH ? {g8[7:4], g8[7:4]} : g8;
    assign b_x   = HALF_DEPTH ? {b8[7:4], b8[7:4]} : b8;
    assign de    = ~(hbl | vbl);
    assign fx_m1 = fx - 3'd1;
    assign sl    = (fx != 3'd0) ? fx_m1[1:0] : 2'd0;

    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            VGA_R    <= '0;
            VGA_G    <= '0;
            VGA_B    <= '0;
            VGA_HS   <= 1'b0;
            VGA_VS   <= 1'b0;
            VGA_DE   <= 1'b0;
            VGA_SL   <= '0;
            CE_PIXEL <= 1'b0;
        end else begin
            CE_PIXEL <= ce;
            if (ce) begin
                VGA_HS <= hs;
                VGA_VS <= vs;
                VGA_DE <= de;
                VGA_SL <= sl;
                VGA_R  <= de ? r_x : 8'd0;
                VGA_G  <= de ? g_x : 8'd0;
                VGA_B  <= de ? b_x : 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_arcade_sync_mixer.sv
// Bench for arcade_sync_mixer (DW=8): a full-depth and a half-depth instance share one
// stimulus stream; a raster generator plus reference model drives the randomized scenarios.

module tb_arcade_sync_mixer;
    logic       clk_video = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic [7:0] RGB_in = '0;
    logic       HBlank = 1'b0, VBlank = 1'b0, HSync = 1'b0, VSync = 1'b0;
    logic [2:0] fx = '0;

    logic [7:0] f_r, f_g, f_b, h_r, h_g, h_b;
    logic       f_hs, f_vs, f_de, f_ce, h_hs, h_vs, h_de, h_ce;
    logic [1:0] f_sl, h_sl;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] due;
        logic        chk;
        logic        hs, vs, de;
        logic [1:0]  sl;
        logic [23:0] rgb_f, rgb_h;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    logic prev_ce = 1'b0, m_hs = 1'b0, m_vs = 1'b0, m_hbl = 1'b0, m_vbl = 1'b0;
    logic pol_h = 1'b0, pol_v = 1'b0;

    arcade_sync_mixer #(.DW(8), .HALF_DEPTH(1'b0), .CNT_W(20)) dut_full (
        .clk_video(clk_video), .reset(reset), .ce_pix(ce_pix), .RGB_in(RGB_in),
        .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync), .fx(fx),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_DE(f_de), .VGA_SL(f_sl), .CE_PIXEL(f_ce)
    );
    arcade_sync_mixer #(.DW(8), .HALF_DEPTH(1'b1), .CNT_W(20)) dut_half (
        .clk_video(clk_video), .reset(reset), .ce_pix(ce_pix), .RGB_in(RGB_in),
        .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync), .fx(fx),
        .VGA_R(h_r), .VGA_G(h_g), .VGA_B(h_b), .VGA_HS(h_hs), .VGA_VS(h_vs),
        .VGA_DE(h_de), .VGA_SL(h_sl), .CE_PIXEL(h_ce)
    );

    always #5 clk_video = ~clk_video;

    task automatic step();
        @(posedge clk_video);
        cyc++;
        #1;
    endtask

    // Bit-replicate each packed field (3R3G2B) cyclically to fill 8 bits.
    function automatic logic [23:0] expand(input logic [7:0] p, input bit half);
        int         w[3];
        int         lsb[3];
        logic [7:0] f, c;
        logic [23:0] res;
        w = '{3, 3, 2};
        lsb = '{5, 2, 0};
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            f = (p >> lsb[ch]) & ((8'd1 << w[ch]) - 8'd1);
            for (int k = 7; k >= 0; k--)
                c[k] = f[w[ch] - 1 - ((7 - k) % w[ch])];
            if (half)
                c = {c[7:4], c[7:4]};
            res = (res << 8) | 24'(c);
        end
        return res;
    endfunction

    function automatic logic [1:0] sl_model(input logic [2:0] f);
        int v;
        v = (f == 0) ? 0 : (int'(f) - 1) % 4;
        return 2'(v);
    endfunction

    // Drive inputs for the next edge; on a ce_pix rising edge, predict the resulting outputs.
    task automatic drive(input logic ce, input logic [7:0] rgb, input logic hb, input logic vb,
                         input logic hsr, input logic vsr, input bit chk);
        exp_t e;
        logic hsf, vsf;
        ce_pix = ce; RGB_in = rgb; HBlank = hb; VBlank = vb; HSync = hsr; VSync = vsr;
        if (ce && !prev_ce) begin
            hsf = hsr ^ pol_h;
            vsf = vsr ^ pol_v;
            if (!m_hs && hsf) m_vs = vsf;
            m_hs = hsf;
            if (m_hbl && !hb) m_vbl = vb;
            m_hbl = hb;
            e.due   = 32'(cyc + 2);
            e.chk   = chk;
            e.hs    = m_hs;
            e.vs    = m_vs;
            e.de    = !(m_hbl || m_vbl);
            e.sl    = sl_model(fx);
            e.rgb_f = e.de ? expand(rgb, 1'b0) : 24'd0;
            e.rgb_h = e.de ? expand(rgb, 1'b1) : 24'd0;
            exp_q.push_back(e);
        end
        prev_ce = ce;
    endtask

    task automatic send_pixel(input logic [7:0] rgb, input logic hb, input logic vb);
        drive(1'b1, rgb, hb, vb, HSync, VSync, 1'b0);
        step();
        drive(1'b0, rgb, hb, vb, HSync, VSync, 1'b0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce_pix = 1'b0; RGB_in = '0; HBlank = 1'b0; VBlank = 1'b0; HSync = 1'b0; VSync = 1'b0;
        step();
        step();
        reset = 1'b0;
        prev_ce = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_hbl = 1'b0; m_vbl = 1'b0;
        pol_h = 1'b0; pol_v = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        fx = 3'd3;
        HSync = 1'b1; VSync = 1'b1;
        send_pixel(8'hFF, 1'b0, 1'b0);
        n_vec++;
        if ({f_ce, f_r, f_hs, f_vs, f_de, f_sl} !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL reset_prefill got ce=%b r=%h hs=%b vs=%b de=%b sl=%0d exp 1 ff 1 1 1 2",
                     f_ce, f_r, f_hs, f_vs, f_de, f_sl);
        end
        #3 reset = 1'b1;
        #1;
        n_vec++;
        if ({f_r, f_g, f_b, f_hs, f_vs, f_de, f_sl, f_ce, h_r, h_ce} !== '0) begin
            n_err++;
            $display("FAIL reset_async_clear got r=%h g=%h b=%h hs=%b vs=%b de=%b sl=%0d ce=%b exp all 0",
                     f_r, f_g, f_b, f_hs, f_vs, f_de, f_sl, f_ce);
        end
        HSync = 1'b0; VSync = 1'b0;
        step();
        step();
        reset = 1'b0;
        prev_ce = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_hbl = 1'b0; m_vbl = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (f_ce !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle_ce cycle %0d got ce=%b exp 0", i, f_ce);
            end
        end
        // ce_pix held high for four clocks: one pulse, two edges after the rise.
        ce_pix = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_vec++;
            if (f_ce !== (i == 2)) begin
                n_err++;
                $display("FAIL reset_first_edge step %0d got ce=%b exp %b", i, f_ce, (i == 2));
            end
        end
        ce_pix = 1'b0;
        step();
    endtask

    task automatic test_expansion();
        logic [7:0] p;
        do_reset();
        fx = 3'd0;
        send_pixel(8'b101_011_10, 1'b0, 1'b0);
        n_vec++;
        if ({f_r, f_g, f_b, h_r, h_g, h_b} !== {24'hB66DAA, 24'hBB66AA}) begin
            n_err++;
            $display("FAIL expand_fixed got full=%h%h%h half=%h%h%h exp b66daa bb66aa",
                     f_r, f_g, f_b, h_r, h_g, h_b);
        end
        for (int i = 0; i < 10; i++) begin
            p = 8'($urandom_range(0, 255));
            send_pixel(p, 1'b0, 1'b0);
            n_vec++;
            if ({f_r, f_g, f_b, h_r, h_g, h_b} !== {expand(p, 1'b0), expand(p, 1'b1)}) begin
                n_err++;
                $display("FAIL expand_random in=%h got full=%h%h%h half=%h%h%h exp %h %h",
                         p, f_r, f_g, f_b, h_r, h_g, h_b, expand(p, 1'b0), expand(p, 1'b1));
            end
        end
    endtask

    task automatic test_blanking();
        logic hb_t[9];
        logic vb_t[9];
        logic de_t[9];
        hb_t = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
        vb_t = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        de_t = '{1, 0, 1, 1, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_pixel(8'hFF, hb_t[i], vb_t[i]);
            n_vec++;
            if ({f_de, f_r, f_g, f_b, h_r} !== {de_t[i], {32{de_t[i]}}}) begin
                n_err++;
                $display("FAIL blanking step %0d hb=%b vb=%b got de=%b rgb=%h%h%h exp de=%b",
                         i, hb_t[i], vb_t[i], f_de, f_r, f_g, f_b, de_t[i]);
            end
        end
    endtask

    task automatic test_ce_timing();
        int pulses;
        do_reset();
        pulses = 0;
        for (int t = 0; t < 24; t++) begin
            ce_pix = ((t % 4) != 3);
            step();
            pulses += int'(f_ce);
            n_vec++;
            if (f_ce !== (((t + 1) % 4) == 2) || h_ce !== f_ce) begin
                n_err++;
                $display("FAIL ce_timing step %0d got ce=%b/%b exp %b", t + 1, f_ce, h_ce,
                         (((t + 1) % 4) == 2));
            end
        end
        n_vec++;
        if (pulses != 6) begin
            n_err++;
            $display("FAIL ce_pulse_count got %0d exp 6", pulses);
        end
        ce_pix = 1'b0;
        step();
    endtask

    task automatic test_sl();
        logic [2:0] fx_t[6];
        logic [1:0] sl_t[6];
        fx_t = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd2, 3'd7};
        sl_t = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fx = fx_t[i];
            send_pixel(8'h55, 1'b0, 1'b0);
            n_vec++;
            if (f_sl !== sl_t[i] || h_sl !== sl_t[i]) begin
                n_err++;
                $display("FAIL scanline fx=%0d got %0d exp %0d", fx_t[i], f_sl, sl_t[i]);
            end
        end
    endtask

    // Raster of 8 lines x 64 clocks: 4-clk hsync, 2-line vsync, VBlank edges placed mid-line.
    task automatic test_raster(input logic hpol, input logic vpol, input int warm, input int frames);
        int   total, line, x, vcut;
        logic hsr, vsr, hb, vb, ce;
        exp_t e;
        do_reset();
        fx = 3'($urandom_range(0, 7));
        pol_h = hpol;
        pol_v = vpol;
        total = (warm + frames) * 512;
        vcut = 20;
        for (int t = 0; t < total + 4; t++) begin
            line = (t / 64) % 8;
            x    = t % 64;
            if (x == 0 && line == 0) vcut = $urandom_range(5, 35);
            hsr = ((x >= 48) && (x < 52)) ^ hpol;
            vsr = ((line == 3 && x >= 50) || line == 4 || (line == 5 && x < 50)) ^ vpol;
            hb  = (x >= 40);
            vb  = (line < 2) || (line == 2 && x < vcut) || (line == 7 && x >= vcut);
            ce  = (t < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(ce, 8'($urandom_range(0, 255)), hb, vb, hsr, vsr, t >= warm * 512);
            step();
            if (exp_q.size() != 0 && exp_q[0].due == 32'(cyc)) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if ({f_ce, h_ce, f_hs, f_vs, f_de, f_sl, f_r, f_g, f_b, h_r, h_g, h_b} !==
                        {2'b11, e.hs, e.vs, e.de, e.sl, e.rgb_f, e.rgb_h}) begin
                        n_err++;
                        $display("FAIL raster_pixel cyc=%0d got ce=%b%b hs=%b vs=%b de=%b sl=%0d rgb=%h%h%h/%h%h%h exp hs=%b vs=%b de=%b sl=%0d rgb=%h/%h",
                                 cyc, f_ce, h_ce, f_hs, f_vs, f_de, f_sl, f_r, f_g, f_b, h_r, h_g, h_b,
                                 e.hs, e.vs, e.de, e.sl, e.rgb_f, e.rgb_h);
                    end
                end
            end else if (t >= warm * 512) begin
                n_vec++;
                if (f_ce !== 1'b0 || h_ce !== 1'b0) begin
                    n_err++;
                    $display("FAIL raster_ce_spurious cyc=%0d got ce=%b%b exp 00", cyc, f_ce, h_ce);
                end
            end
        end
    endtask

    task automatic test_polarity();
        test_raster(1'b1, 1'b0, 2, 1);
        test_raster(1'b0, 1'b1, 2, 1);
    endtask

    task automatic test_random_raster();
        test_raster(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 2);
    endtask

    initial begin
        test_reset();
        test_expansion();
        test_blanking();
        test_ce_timing();
        test_sl();
        test_polarity();
        test_random_raster();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
